gcd_io_sequencer: RTL and testbench



---
 rtl/gcd_io_sequencer.sv | 141 ++++++++++++++
 tb/tb_gcd_io_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_io_sequencer.sv
// ============================================================================
// Module  : gcd_io_sequencer
// Purpose : Handshake front-end for the subtractive GCD core. It serialises
//           operand pairs onto the core bus, bounds each run with a timeout and
//           resolves zero operands locally.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_io_sequencer #(
  parameter  int WIDTH   = 16,
  parameter  int TIMEOUT = 1023,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CW-1:0]    out_cycles,
  output logic             out_err,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             fire;
  logic             a_zero;
  logic             b_zero;

  assign fire   = in_valid && in_ready;
  assign a_zero = (in_a == '0);
  assign b_zero = (in_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (fire) begin
          next_state = (a_zero || b_zero) ? S_HOLD : S_LOAD_A;
        end
      end
      S_LOAD_A: next_state = S_LOAD_B;
      S_LOAD_B: next_state = S_RUN;
      S_RUN: begin
        if (core_done || (cnt == CNT_MAX)) begin
          next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_gcd    <= '0;
      out_cycles <= '0;
      out_err    <= 1'b0;
      core_start <= 1'b0;
      core_data  <= '0;
      b_q        <= '0;
      cnt        <= '0;
    end else begin
      in_ready   <= (next_state == S_IDLE);
      out_valid  <= (next_state == S_HOLD);
      core_start <= (next_state == S_LOAD_A);
      case (state)
        S_IDLE: begin
          if (fire) begin
            b_q <= in_b;
            cnt <= '0;
            if (a_zero && b_zero) begin
              out_gcd    <= '0;
              out_cycles <= '0;
              out_err    <= 1'b1;
            end else if (a_zero || b_zero) begin
              out_gcd    <= a_zero ? in_b : in_a;
              out_cycles <= '0;
              out_err    <= 1'b0;
            end else begin
              core_data <= in_a;
            end
          end
        end
        S_LOAD_A: core_data <= b_q;
        S_LOAD_B: cnt <= CW'(1);
        S_RUN: begin
          // A done in the final allowed cycle still counts as success.
          if (core_done) begin
            out_gcd    <= core_result;
            out_cycles <= cnt;
            out_err    <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            out_gcd    <= '0;
            out_cycles <= CNT_MAX;
            out_err    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gcd_io_sequencer.sv
// Scoreboard bench for gcd_io_sequencer with a behavioural core stand-in.
`default_nettype none

module tb_gcd_io_sequencer;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(TIMEOUT + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [CW-1:0]    out_cycles;
  logic             out_err;
  logic             core_start;
  logic [WIDTH-1:0] core_data;
  logic             core_done;
  logic [WIDTH-1:0] core_result;

  gcd_io_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_cycles(out_cycles), .out_err(out_err),
    .core_start(core_start), .core_data(core_data),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [CW-1:0]    c;
    logic             e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Core stand-in: latches A on start, B on the next edge, then asserts done
  // in RUN cycle done_at (0 means never) returning core_res.
  int               done_at  = 0;
  logic [WIDTH-1:0] core_res = '0;
  logic [1:0]       phase;
  int               run;
  logic [WIDTH-1:0] seen_a;
  logic [WIDTH-1:0] seen_b;
  int               start_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 2'd0;
      run   <= 0;
    end else if (core_start) begin
      phase  <= 2'd1;
      seen_a <= core_data;
    end else if (phase == 2'd1) begin
      seen_b <= core_data;
      phase  <= 2'd2;
      run    <= 1;
    end else if (phase == 2'd2) begin
      run <= run + 1;
    end
  end

  always @(posedge clk) if (core_start) start_cnt++;

  assign core_done   = (phase == 2'd2) && (done_at != 0) && (run == done_at);
  assign core_result = core_res;

  // Monitor: each accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_gcd", out_gcd, e.g);
        chk("out_cycles", out_cycles, e.c);
        chk("out_err", out_err, e.e);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_gcd"}, out_gcd, 0);
    chk({tag, "_out_cycles"}, out_cycles, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_data"}, core_data, 0);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int dat, input logic [WIDTH-1:0] r,
                      input logic [WIDTH-1:0] eg, input logic [CW-1:0] ec,
                      input logic ee, output int waited);
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", 0, 1);
    end else begin
      in_a = a; in_b = b; done_at = dat; core_res = r; in_valid = 1'b1;
      sb.push_back({eg, ec, ee});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_result();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_timeout_queue", sb.size(), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int s0;
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal pair, operand sequencing on the core bus.
    s0 = start_cnt;
    send(16'd48, 16'd18, 5, 16'd6, 16'd6, 4'd5, 1'b0, w);
    chk("load_a_start", core_start, 1);
    chk("load_a_data", core_data, 48);
    in_a = 16'hFFFF; in_b = 16'hFFFF;
    @(posedge clk); #1;
    chk("load_b_start", core_start, 0);
    chk("load_b_data", core_data, 18);
    wait_result();
    chk("core_saw_a", seen_a, 48);
    chk("core_saw_b", seen_b, 18);
    chk("one_start", start_cnt - s0, 1);

    // Backpressure: result held, in_valid ignored.
    out_ready = 1'b0;
    s0 = start_cnt;
    send(16'd35, 16'd14, 3, 16'd7, 16'd7, 4'd3, 1'b0, w);
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_a = 16'(i + 3); in_b = 16'(i + 4);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_gcd", out_gcd, 7);
      chk("bp_out_cycles", out_cycles, 3);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_result();
    cycles(3);
    chk("bp_no_extra_start", start_cnt - s0, 1);

    // Zero bypasses.
    s0 = start_cnt;
    send(16'd0, 16'd21, 0, 16'd0, 16'd21, 4'd0, 1'b0, w);
    chk("bypass_latency_valid", out_valid, 1);
    wait_result();
    send(16'd9, 16'd0, 0, 16'd0, 16'd9, 4'd0, 1'b0, w);
    wait_result();
    send(16'd0, 16'd0, 0, 16'd0, 16'd0, 4'd0, 1'b1, w);
    wait_result();
    chk("bypass_no_start", start_cnt - s0, 0);

    // Timeout, and done coinciding with the last allowed cycle.
    send(16'd12, 16'd8, 0, 16'd0, 16'd0, 4'd8, 1'b1, w);
    wait_result();
    send(16'd15, 16'd10, 8, 16'd5, 16'd5, 4'd8, 1'b0, w);
    wait_result();
    send(16'd9, 16'd6, 1, 16'd3, 16'd3, 4'd1, 1'b0, w);
    wait_result();

    // Back-to-back pairs.
    send(16'd35, 16'd14, 4, 16'd7, 16'd7, 4'd4, 1'b0, w);
    send(16'd17, 16'd5, 3, 16'd1, 16'd1, 4'd3, 1'b0, w);
    chk("b2b_second_waited", (w > 0), 1);
    wait_result();

    // Reset mid-RUN discards the pending result.
    send(16'd48, 16'd18, 6, 16'd6, 16'd6, 4'd6, 1'b0, w);
    cycles(3);
    #3 rst_n = 1'b0;
    #1 check_reset_values("midrun");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    chk("post_reset_in_ready", in_ready, 1);
    cycles(20);
    chk("post_reset_no_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
